// File: rtl/clk_activity_monitor.sv
// Frequency-band and stall monitor for a free-running test clock.
// Counts MCLK rising edges over a fixed window of CLK cycles and grades the result.
`timescale 1ns/1ps

module clk_activity_monitor #(
    parameter int WINDOW      = 256,
    parameter int CNT_W       = 16,
    parameter int MIN_EDGES   = 60,
    parameter int MAX_EDGES   = 68,
    parameter int STALL_LIMIT = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MCLK,
    input  logic             START,
    input  logic             CONTINUOUS,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] EDGE_COUNT,
    output logic             IN_RANGE,
    output logic             TOO_SLOW,
    output logic             TOO_FAST,
    output logic             STALLED
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int STL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_EDGES);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [STL_W-1:0] STALL_MAX = STL_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t             state_r;
    logic               sync1_r;
    logic               sync2_r;
    logic               prev_r;
    logic               rise_s;
    logic               arm_cnt_r;
    logic [WIN_W-1:0]   win_cnt_r;
    logic [CNT_W-1:0]   edge_cnt_r;
    logic [CNT_W-1:0]   edge_inc_s;
    logic [STL_W-1:0]   stall_cnt_r;
    logic [STL_W-1:0]   stall_next_s;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   edge_count_r;
    logic               in_range_r;
    logic               too_slow_r;
    logic               too_fast_r;
    logic               stalled_r;

    assign rise_s = sync2_r & ~prev_r;

    // Saturating edge-count and stall-count next values
    always_comb begin
        edge_inc_s   = edge_cnt_r;
        stall_next_s = stall_cnt_r;
        if (rise_s && (edge_cnt_r != CNT_MAX)) begin
            edge_inc_s = edge_cnt_r + CNT_W'(1);
        end else begin
            edge_inc_s = edge_cnt_r;
        end
        if (rise_s) begin
            stall_next_s = '0;
        end else if (stall_cnt_r != STALL_MAX) begin
            stall_next_s = stall_cnt_r + STL_W'(1);
        end else begin
            stall_next_s = stall_cnt_r;
        end
    end

    // Synchroniser, stall tracking, measurement FSM and result registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= IDLE;
            sync1_r      <= 1'b0;
            sync2_r      <= 1'b0;
            prev_r       <= 1'b0;
            arm_cnt_r    <= 1'b0;
            win_cnt_r    <= '0;
            edge_cnt_r   <= '0;
            stall_cnt_r  <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            edge_count_r <= '0;
            in_range_r   <= 1'b0;
            too_slow_r   <= 1'b0;
            too_fast_r   <= 1'b0;
            stalled_r    <= 1'b0;
        end else begin
            sync1_r     <= MCLK;
            sync2_r     <= sync1_r;
            prev_r      <= sync2_r;
            stall_cnt_r <= stall_next_s;
            stalled_r   <= (stall_next_s == STALL_MAX);
            done_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        state_r   <= ARM;
                        busy_r    <= 1'b1;
                        arm_cnt_r <= 1'b0;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ARM: begin
                    // Two cycles let stale synchroniser contents drain before counting
                    win_cnt_r  <= '0;
                    edge_cnt_r <= '0;
                    if (arm_cnt_r) begin
                        state_r <= MEASURE;
                    end else begin
                        arm_cnt_r <= 1'b1;
                    end
                end
                MEASURE: begin
                    edge_cnt_r <= edge_inc_s;
                    if (win_cnt_r == WIN_LAST) begin
                        state_r <= REPORT;
                    end else begin
                        win_cnt_r <= win_cnt_r + WIN_W'(1);
                    end
                end
                REPORT: begin
                    edge_count_r <= edge_cnt_r;
                    too_slow_r   <= (edge_cnt_r < MIN_C);
                    too_fast_r   <= (edge_cnt_r > MAX_C);
                    in_range_r   <= (edge_cnt_r >= MIN_C) && (edge_cnt_r <= MAX_C);
                    done_r       <= 1'b1;
                    win_cnt_r    <= '0;
                    edge_cnt_r   <= '0;
                    if (CONTINUOUS) begin
                        state_r <= MEASURE;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY       = busy_r;
    assign DONE       = done_r;
    assign EDGE_COUNT = edge_count_r;
    assign IN_RANGE   = in_range_r;
    assign TOO_SLOW   = too_slow_r;
    assign TOO_FAST   = too_fast_r;
    assign STALLED    = stalled_r;

endmodule

// File: tb/tb_clk_activity_monitor.sv
// Scoreboard bench for clk_activity_monitor: expected windows queued at START,
// matched against DONE events captured by a monitor.
`timescale 1ns/1ps

module tb_clk_activity_monitor;

    logic clk = 1'b0, reset = 1'b1, mclk = 1'b0;
    logic start = 1'b0, start_sat = 1'b0, continuous = 1'b0;
    logic busy, done, in_range, too_slow, too_fast, stalled;
    logic [15:0] edge_count;
    logic s_busy, s_done, s_in, s_slow, s_fast, s_stalled;
    logic [3:0] s_count;

    int mclk_half = 20;
    bit mclk_en   = 1'b1;
    int cyc = 0, checks = 0, errors = 0;

    typedef struct {int lo; int hi; logic [2:0] flags; int cyc; logic busy;} exp_t;
    typedef struct {int cnt; logic [2:0] flags; int cyc; logic busy;} obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];

    clk_activity_monitor dut (
        .CLK(clk), .RESET(reset), .MCLK(mclk), .START(start), .CONTINUOUS(continuous),
        .BUSY(busy), .DONE(done), .EDGE_COUNT(edge_count), .IN_RANGE(in_range),
        .TOO_SLOW(too_slow), .TOO_FAST(too_fast), .STALLED(stalled)
    );

    clk_activity_monitor #(.CNT_W(4), .MIN_EDGES(8), .MAX_EDGES(12)) dut_sat (
        .CLK(clk), .RESET(reset), .MCLK(mclk), .START(start_sat), .CONTINUOUS(1'b0),
        .BUSY(s_busy), .DONE(s_done), .EDGE_COUNT(s_count), .IN_RANGE(s_in),
        .TOO_SLOW(s_slow), .TOO_FAST(s_fast), .STALLED(s_stalled)
    );

    always #5 clk = ~clk;

    always begin
        #(mclk_half);
        if (mclk_en) mclk = ~mclk;
        else mclk = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1)
            obs_q.push_back('{cnt: int'(edge_count), flags: {too_fast, in_range, too_slow},
                              cyc: cyc, busy: busy});
    end

    task automatic collect(input int budget, output obs_t o, output exp_t e, output bit ok);
        int n = 0;
        while (obs_q.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (obs_q.size() != 0) && (exp_q.size() != 0);
        o = '{cnt: 0, flags: 3'b000, cyc: 0, busy: 1'b0};
        e = '{lo: 0, hi: 0, flags: 3'b000, cyc: 0, busy: 1'b0};
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
        end
    endtask

    task automatic pulse_start(input bit both, output int s);
        @(negedge clk);
        start = 1'b1;
        start_sat = both;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        start_sat = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, in_range, too_slow, too_fast, stalled, edge_count} !== 22'd0) begin
            errors++;
            $display("FAIL reset_main: got %b/%0d, want all 0",
                     {busy, done, in_range, too_slow, too_fast, stalled}, edge_count);
        end
        checks++;
        if ({s_busy, s_done, s_in, s_slow, s_fast, s_stalled, s_count} !== 10'd0) begin
            errors++;
            $display("FAIL reset_sat: got %b/%0d, want all 0",
                     {s_busy, s_done, s_in, s_slow, s_fast, s_stalled}, s_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_band(input string name, input int half, input int lo, input int hi,
                             input logic [2:0] flags, input bit sat);
        int s;
        obs_t o;
        exp_t e;
        bit ok;
        mclk_half = half;
        repeat (20) @(negedge clk);
        pulse_start(sat, s);
        exp_q.push_back('{lo: lo, hi: hi, flags: flags, cyc: s + 260, busy: 1'b0});
        collect(400, o, e, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done: got no DONE, want DONE at cycle %0d", name, s + 260);
        end else begin
            checks++;
            if (o.cnt < e.lo || o.cnt > e.hi) begin
                errors++;
                $display("FAIL %s_count: got %0d, want %0d..%0d", name, o.cnt, e.lo, e.hi);
            end
            checks++;
            if (o.flags !== e.flags) begin
                errors++;
                $display("FAIL %s_flags: got %b, want %b", name, o.flags, e.flags);
            end
            checks++;
            if (o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL %s_latency: got cycle %0d, want %0d", name, o.cyc, e.cyc);
            end
            checks++;
            if (o.busy !== e.busy) begin
                errors++;
                $display("FAIL %s_busy: got %b, want %b", name, o.busy, e.busy);
            end
        end
        if (sat) begin
            checks++;
            if (s_count !== 4'd15 || {s_fast, s_in, s_slow} !== 3'b100) begin
                errors++;
                $display("FAIL %s_saturate: got %0d/%b, want 15/100", name, s_count,
                         {s_fast, s_in, s_slow});
            end
        end
    endtask

    task automatic test_stall();
        int t0, s, n, k;
        obs_t o;
        exp_t e;
        bit ok;
        mclk_half = 20;
        mclk_en = 1'b0;
        t0 = cyc;
        repeat (10) @(negedge clk);
        pulse_start(1'b0, s);
        exp_q.push_back('{lo: 0, hi: 0, flags: 3'b001, cyc: s + 260, busy: 1'b0});
        while (cyc < t0 + 55) @(negedge clk);
        checks++;
        if (stalled !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: got %b, want 0", stalled);
        end
        while (cyc < t0 + 75) @(negedge clk);
        checks++;
        if (stalled !== 1'b1) begin
            errors++;
            $display("FAIL stall_set: got %b, want 1", stalled);
        end
        collect(400, o, e, ok);
        checks++;
        if (!ok || o.cnt !== e.lo || o.flags !== e.flags || o.cyc !== e.cyc) begin
            errors++;
            $display("FAIL stall_window: got ok=%b cnt=%0d flags=%b cyc=%0d, want cnt=0 flags=001 cyc=%0d",
                     ok, o.cnt, o.flags, o.cyc, s + 260);
        end
        mclk_en = 1'b1;
        n = 0;
        while (mclk !== 1'b1 && n < 200) begin
            #1;
            n++;
        end
        k = 0;
        while (stalled !== 1'b0 && k < 4) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (stalled !== 1'b0) begin
            errors++;
            $display("FAIL stall_clear: got %b after %0d cycles, want 0", stalled, k);
        end
    endtask

    task automatic test_continuous();
        int s, d;
        obs_t o;
        exp_t e;
        bit ok;
        mclk_half = 20;
        repeat (20) @(negedge clk);
        continuous = 1'b1;
        pulse_start(1'b0, s);
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{lo: 63, hi: 65, flags: 3'b010, cyc: s + 260 + 257 * i,
                              busy: (i == 3) ? 1'b0 : 1'b1});
        for (int i = 0; i < 4; i++) begin
            collect(400, o, e, ok);
            checks++;
            if (!ok || o.cnt < e.lo || o.cnt > e.hi || o.flags !== e.flags ||
                o.cyc !== e.cyc || o.busy !== e.busy) begin
                errors++;
                $display("FAIL cont_done%0d: got ok=%b cnt=%0d flags=%b cyc=%0d busy=%b, want cnt=%0d..%0d flags=%b cyc=%0d busy=%b",
                         i, ok, o.cnt, o.flags, o.cyc, o.busy, e.lo, e.hi, e.flags, e.cyc, e.busy);
            end
            if (i < 3) pulse_start(1'b0, d);
            if (i == 2) continuous = 1'b0;
        end
        repeat (300) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: got %0d extra DONEs busy=%b, want 0 and 0", obs_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        pulse_start(1'b0, s);
        repeat (102) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, in_range, too_slow, too_fast, stalled, edge_count} !== 22'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b/%0d, want all 0",
                     {busy, done, in_range, too_slow, too_fast, stalled}, edge_count);
        end
        reset = 1'b0;
        repeat (300) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_nodone: got %0d DONEs, want 0", obs_q.size());
        end
        test_band("fresh", 20, 63, 65, 3'b010, 1'b0);
    endtask

    initial begin
        test_reset();
        test_band("in_range", 20, 63, 65, 3'b010, 1'b1);
        test_band("too_slow", 40, 31, 33, 3'b001, 1'b0);
        test_band("too_fast", 15, 84, 86, 3'b100, 1'b0);
        test_stall();
        test_continuous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_activity_monitor.md
Name: clk_activity_monitor

Overview:
- Measures a free-running test clock against the system clock and reports whether its frequency is within a programmed band.
- Counts rising edges of a monitored clock over a fixed window of system-clock cycles.
- Raises a live stall flag when the monitored clock stops.
- Sits in the FIFO test environment next to the clock generators and checks the write- and read-clock waveforms they produce, one instance per clock.

Parameters:
- WINDOW, 256: measurement window length in CLK cycles (>= 4).
- CNT_W, 16: width of the edge counter and EDGE_COUNT.
- MIN_EDGES, 60: lowest edge count accepted as in-range.
- MAX_EDGES, 68: highest edge count accepted as in-range (MIN_EDGES <= MAX_EDGES).
- STALL_LIMIT, 64: number of CLK cycles without a monitored edge before STALLED asserts.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- MCLK  in  1  monitored clock, asynchronous to CLK; its frequency must be < CLK/2.
- START  in  1  request a measurement; sampled only in IDLE.
- CONTINUOUS  in  1  when 1, REPORT returns to MEASURE instead of IDLE.
- BUSY  out  1  1 in any state other than IDLE.
- DONE  out  1  one-cycle pulse when the result registers update.
- EDGE_COUNT  out  CNT_W  edge count of the last completed window.
- IN_RANGE  out  1  MIN_EDGES <= count <= MAX_EDGES for the last window.
- TOO_SLOW  out  1  count < MIN_EDGES for the last window.
- TOO_FAST  out  1  count > MAX_EDGES for the last window.
- STALLED  out  1  live: no MCLK rising edge for >= STALL_LIMIT CLK cycles.

Behaviour:
- Synchroniser: MCLK passes through two flops, then a third "previous" flop. Edge detect `rise = sync2 & ~prev`.
- Reset: all flops go to 0, state = IDLE. All outputs are 0 on the cycle after RESET is sampled high. Reset mid-measurement abandons the window and leaves no DONE pulse.
- FSM states: IDLE, ARM, MEASURE, REPORT.
  - IDLE: START=1 moves to ARM on the next cycle.
  - ARM: lasts exactly 2 cycles to flush the synchroniser. The window counter and edge counter are cleared. Then moves to MEASURE.
  - MEASURE: the window counter runs 0..WINDOW-1, for exactly WINDOW cycles. The edge counter increments on each `rise` seen in MEASURE. The edge counter saturates at 2^CNT_W-1 and never wraps. After the cycle with window counter = WINDOW-1, moves to REPORT.
    - A `rise` in the final MEASURE cycle is counted.
    - A `rise` in ARM or REPORT is not counted.
  - REPORT: one cycle.
    - EDGE_COUNT, IN_RANGE, TOO_SLOW and TOO_FAST are registered from the final count and become visible on the cycle after REPORT.
    - DONE=1 on that same cycle.
    - Next state: MEASURE if CONTINUOUS=1 (counters cleared, no ARM), otherwise IDLE.
- Result flags: exactly one of IN_RANGE, TOO_SLOW, TOO_FAST is 1 after the first report. The comparison uses the saturated count. All three hold their value until the next report.
- START outside IDLE is ignored. START held high in IDLE after a report starts a new measurement, which re-enters through ARM.
- CONTINUOUS is sampled only in REPORT. Dropping it mid-window ends the sequence after the current report.
- Latency: a START pulse in IDLE produces DONE exactly WINDOW+4 cycles later (1 + 2 ARM + WINDOW + 1 REPORT). Back-to-back continuous DONEs are WINDOW+1 cycles apart.
- Stall counter: runs in every state except reset.
  - Clears on `rise`.
  - Otherwise increments, saturating at STALL_LIMIT.
  - STALLED = (stall counter == STALL_LIMIT).
  - STALLED deasserts the cycle after the first `rise`.
- The block drives no X on any output.

Test Plan:
- CLK period 10 ns, MCLK period 40 ns, START pulse -> DONE 260 cycles after START, EDGE_COUNT in 63..65, IN_RANGE=1, TOO_SLOW=TOO_FAST=0, BUSY=0 after DONE.
- MCLK period 80 ns -> EDGE_COUNT in 31..33, TOO_SLOW=1. MCLK period 30 ns -> EDGE_COUNT in 84..86, TOO_FAST=1.
- MCLK held at 0, START -> STALLED=1 from 64 cycles after the last edge, EDGE_COUNT=0, TOO_SLOW=1. Restart MCLK -> STALLED=0 within 4 cycles of the first MCLK rise.
- CNT_W=4, MCLK period 40 ns -> EDGE_COUNT=15 (saturated), TOO_FAST=1 with MAX_EDGES=12, MIN_EDGES=8.
- CONTINUOUS=1, three windows -> DONE pulses exactly 257 cycles apart. START pulses during BUSY have no effect. Clearing CONTINUOUS mid-window -> IDLE after that window's DONE.
- RESET asserted 100 cycles into MEASURE -> next cycle all outputs 0, state IDLE, no DONE. A following START yields a full fresh window with correct count.
